// File: rtl/bus_arb4.sv
// ---------------------------------------------------------------------------
// bus_arb4 -- four-requester round-robin bus arbiter with turnaround cycle
//
// Purpose
//   Grants ownership of a shared bus to one of four requesters. A winner is
//   chosen by round-robin starting at the rotating pointer ptr. Ownership
//   lasts while the owner keeps its request high. Every release is followed
//   by a one-cycle TURN state and then an IDLE cycle before the next grant.
//   The select output keeps the last owner's index between grants, so the
//   shared 4:1 data mux stays stable while the bus is idle.
//
// Optional feature
//   `define ARB_TIMEOUT_EN compiles in a hold watchdog. An owner is forced
//   off the bus after MAX_HOLD consecutive grant cycles. timeout pulses for
//   the first TURN cycle after such a forced release. Without the macro no
//   hold counter exists and timeout is tied low.
//
// Parameters
//   MAX_HOLD     maximum consecutive grant cycles per ownership (2..255).
//                Only used when ARB_TIMEOUT_EN is defined.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   req[3:0]     per-requester request, held high while ownership is wanted
//   gnt[3:0]     registered one-hot grant; all zero when there is no owner
//   slct[1:0]    binary index of the current or last owner (mux select)
//   busy         high while any gnt bit is high
//   timeout      one-cycle pulse on a forced release
//   dbg_state_o  FSM state (0 IDLE, 1 GRANT, 2 TURN), for observation only
//   dbg_ptr_o    round-robin pointer, for observation only
// ---------------------------------------------------------------------------
module bus_arb4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] slct,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] dbg_state_o,
    output logic [1:0] dbg_ptr_o
);

    // Handshake: requester i raises req[i] and holds it while it wants the
    // bus. gnt[i] rises one cycle after req[i] is sampled in IDLE (if i wins)
    // and stays up while req[i] stays high. Dropping req[i] ends the
    // ownership at the next edge. A request that is low at the IDLE sampling
    // edge is simply not seen; there is no latched request.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Elaboration-time range check on the hold limit.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arb4: MAX_HOLD must be in 2..255");
    end

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] slct_q;
    logic [1:0] ptr_q;

    // Round-robin pick, combinational from the current pointer and request.
    logic [1:0] pick_idx_d;
    logic       pick_vld_d;

`ifdef ARB_TIMEOUT_EN
    // The hold counter counts completed grant cycles minus one. Release is
    // therefore forced at the edge where it reads MAX_HOLD-1, which gives
    // exactly MAX_HOLD cycles of gnt.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q;
    logic       timeout_q;
`endif

    // Scan offsets 3 down to 0 so that the smallest offset from ptr, which
    // is the round-robin winner, is the last one to be assigned.
    always_comb begin
        pick_idx_d = ptr_q;
        pick_vld_d = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                pick_idx_d = ptr_q + 2'(k);
                pick_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over everything, including an active grant. There
            // is no TURN cycle after a reset.
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            slct_q    <= 2'b00;
            ptr_q     <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            // timeout is a single-cycle pulse; it is set only on the forced
            // release edge below.
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << pick_idx_d;
                        slct_q  <= pick_idx_d;
                        ptr_q   <= pick_idx_d + 2'd1;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= 8'd0;
`endif
                    end
                end

                GRANT: begin
                    // slct_q holds the owner index for the whole ownership.
                    // Requests on other bits are ignored here.
                    if (!req[slct_q]) begin
                        state_q <= TURN;
                        gnt_q   <= 4'b0000;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_q == HOLD_LAST) begin
                        state_q   <= TURN;
                        gnt_q     <= 4'b0000;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
`endif
                end

                TURN: begin
                    // Bus turnaround: no grant, requests ignored.
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign slct        = slct_q;
    assign busy        = |gnt_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arb4.sv
// ---------------------------------------------------------------------------
// tb_bus_arb4 -- directed testbench for bus_arb4
//
// The driver applies one input vector per cycle on the falling edge and
// pushes the hand-computed outputs expected after the following rising
// edge. The monitor samples 1 ns after each rising edge, pops one
// expectation and compares it. Packed expectation layout:
//   {gnt[3:0], slct[1:0], busy, timeout, state[1:0], ptr[1:0]}
// ---------------------------------------------------------------------------
module tb_bus_arb4;

    localparam int W = 12;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] slct;
    logic       busy;
    logic       timeout;
    logic [1:0] dbg_state_o;
    logic [1:0] dbg_ptr_o;

    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           total = 0;
    int           bad   = 0;
    int           step  = 0;

    bus_arb4 #(.MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .slct        (slct),
        .busy        (busy),
        .timeout     (timeout),
        .dbg_state_o (dbg_state_o),
        .dbg_ptr_o   (dbg_ptr_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Apply one cycle of inputs and queue the outputs expected after the
    // next rising edge.
    task automatic cyc(input logic r, input logic [3:0] rq,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic et, input logic [1:0] est,
                       input logic [1:0] ep);
        @(negedge clk);
        rst = r;
        req = rq;
        step++;
        exp_q.push_back({eg, es, (eg != 4'b0000), et, est, ep});
        id_q.push_back(step);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        int           id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                id    = id_q.pop_front();
                act_v = {gnt, slct, busy, timeout, dbg_state_o, dbg_ptr_o};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL step%0d: got gnt=%b slct=%b busy=%b to=%b st=%0d ptr=%0d, want gnt=%b slct=%b busy=%b to=%b st=%0d ptr=%0d",
                             id, act_v[11:8], act_v[7:6], act_v[5], act_v[4], act_v[3:2], act_v[1:0],
                             exp_v[11:8], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:2], exp_v[1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;

        // A: reset state, then a single request from index 2.
        cyc(1, 4'b0000, 4'b0000, 2'd0, 0, S_IDLE,  2'd0);
        cyc(1, 4'b1111, 4'b0000, 2'd0, 0, S_IDLE,  2'd0);
        cyc(0, 4'b0100, 4'b0100, 2'd2, 0, S_GRANT, 2'd3);
        cyc(0, 4'b0100, 4'b0100, 2'd2, 0, S_GRANT, 2'd3);
        cyc(0, 4'b0000, 4'b0000, 2'd2, 0, S_TURN,  2'd3);
        cyc(0, 4'b0000, 4'b0000, 2'd2, 0, S_IDLE,  2'd3);

        // B: all four requesting, each owner drops for one cycle after two
        // grant cycles. Order 0,1,2,3,0 including the 3 -> 0 wrap.
        cyc(1, 4'b0000, 4'b0000, 2'd0, 0, S_IDLE,  2'd0);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] o;
            logic [3:0] g;
            o = 2'(k % 4);
            g = 4'b0001 << o;
            cyc(0, 4'b1111,      g,       o, 0, S_GRANT, o + 2'd1);
            cyc(0, 4'b1111,      g,       o, 0, S_GRANT, o + 2'd1);
            cyc(0, 4'b1111 & ~g, 4'b0000, o, 0, S_TURN,  o + 2'd1);
            cyc(0, 4'b1111,      4'b0000, o, 0, S_IDLE,  o + 2'd1);
        end

        // C: owner 1 holds while req[3] rises; 3 waits for release + TURN.
        cyc(0, 4'b0010, 4'b0010, 2'd1, 0, S_GRANT, 2'd2);
        cyc(0, 4'b1010, 4'b0010, 2'd1, 0, S_GRANT, 2'd2);
        cyc(0, 4'b1010, 4'b0010, 2'd1, 0, S_GRANT, 2'd2);
        cyc(0, 4'b1110, 4'b0010, 2'd1, 0, S_GRANT, 2'd2);
        cyc(0, 4'b1000, 4'b0000, 2'd1, 0, S_TURN,  2'd2);
        cyc(0, 4'b1000, 4'b0000, 2'd1, 0, S_IDLE,  2'd2);
        cyc(0, 4'b1000, 4'b1000, 2'd3, 0, S_GRANT, 2'd0);
        cyc(0, 4'b1000, 4'b1000, 2'd3, 0, S_GRANT, 2'd0);
        // Request present during TURN but gone at the IDLE edge: no grant.
        cyc(0, 4'b0000, 4'b0000, 2'd3, 0, S_TURN,  2'd0);
        cyc(0, 4'b0100, 4'b0000, 2'd3, 0, S_IDLE,  2'd0);
        cyc(0, 4'b0000, 4'b0000, 2'd3, 0, S_IDLE,  2'd0);

        // D: reset during ownership of index 0, then again during index 1.
        cyc(0, 4'b0001, 4'b0001, 2'd0, 0, S_GRANT, 2'd1);
        cyc(0, 4'b0001, 4'b0001, 2'd0, 0, S_GRANT, 2'd1);
        cyc(1, 4'b0011, 4'b0000, 2'd0, 0, S_IDLE,  2'd0);
        cyc(0, 4'b0011, 4'b0001, 2'd0, 0, S_GRANT, 2'd1);
        cyc(0, 4'b0011, 4'b0001, 2'd0, 0, S_GRANT, 2'd1);
        cyc(0, 4'b0010, 4'b0000, 2'd0, 0, S_TURN,  2'd1);
        cyc(0, 4'b0010, 4'b0000, 2'd0, 0, S_IDLE,  2'd1);
        cyc(0, 4'b0010, 4'b0010, 2'd1, 0, S_GRANT, 2'd2);
        cyc(1, 4'b0010, 4'b0000, 2'd0, 0, S_IDLE,  2'd0);
        cyc(0, 4'b0000, 4'b0000, 2'd0, 0, S_IDLE,  2'd0);

        // E: req=0011 held from IDLE with ptr=0.
`ifdef ARB_TIMEOUT_EN
        // Forced release after 8 cycles, alternating owners 0 and 1.
        for (int r = 0; r < 4; r++) begin
            logic [1:0] o;
            o = 2'(r % 2);
            for (int c = 0; c < 8; c++)
                cyc(0, 4'b0011, 4'b0001 << o, o, 0, S_GRANT, o + 2'd1);
            cyc(0, 4'b0011, 4'b0000, o, 1, S_TURN, o + 2'd1);
            cyc(0, 4'b0011, 4'b0000, o, 0, S_IDLE, o + 2'd1);
        end
`else
        // Unbounded ownership: index 0 keeps the bus, timeout stays low.
        for (int c = 0; c < 101; c++)
            cyc(0, 4'b0011, 4'b0001, 2'd0, 0, S_GRANT, 2'd1);
`endif

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arb4.md
BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, meaning the maximum consecutive grant cycles per ownership (range 2..255; used only with the timeout feature).
REQ-002 clk  input  1  The single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 req  input  4  Per-requester request; bit i is requester i; held high while ownership is wanted.
REQ-005 gnt  output  4  One-hot grant, registered; all zero when no owner.
REQ-006 slct  output  2  Binary index of the current or last owner; drives the select input of the shared 4:1 mux (00 selects in_00 ... 11 selects in_11).
REQ-007 busy  output  1  High while any gnt bit is high.
REQ-008 timeout  output  1  One-cycle pulse on forced release; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT, TURN.
- IDLE: no owner.
- GRANT: one owner.
- TURN: one-cycle bus turnaround after release.
REQ-010 In IDLE with req != 0 at edge N, the FSM SHALL select a winner by round-robin, move to GRANT, and drive gnt and slct for the winner from cycle N+1 (latency 1).
REQ-011 Round-robin SHALL search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first with req high.
REQ-012 On each grant to index i, ptr SHALL become (i+1) mod 4.
REQ-013 In GRANT, gnt SHALL stay stable while req[owner] is high; req changes on other bits SHALL have no effect.
REQ-014 In GRANT, if req[owner] is low at edge N, gnt SHALL be 0 from N+1 and the FSM SHALL enter TURN.
REQ-015 TURN SHALL always last one cycle, then go to IDLE. No grant is issued in TURN, so at least two idle-gnt cycles separate successive owners at the sampling edge.
REQ-016 slct SHALL be updated only when a new grant is issued. It SHALL hold its value in IDLE and TURN so the mux output stays stable.
REQ-017 gnt SHALL never have more than one bit set, and SHALL never be nonzero outside GRANT.
REQ-018 A req bit that drops in the same cycle it would be granted (IDLE sampling edge) SHALL not be granted.
REQ-019 busy SHALL equal the OR of gnt.
REQ-020 The ptr wrap-around from 3 to 0 SHALL be seamless; no index may be starved when others keep requesting.

Reset
REQ-021 With rst high at a rising edge, the following SHALL hold on the next cycle regardless of state or req:
- gnt = 0000, slct = 00, busy = 0, timeout = 0;
- ptr = 0, hold counter = 0, FSM = IDLE.
REQ-022 Reset asserted mid-ownership SHALL drop the grant at the next edge with no TURN cycle. The first post-reset grant SHALL obey REQ-010 with ptr = 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN SHALL compile in a hold watchdog.
REQ-024 With ARB_TIMEOUT_EN defined:
- An 8-bit hold counter SHALL clear on each grant and increment each GRANT cycle.
- When the owner has held gnt for MAX_HOLD cycles, gnt SHALL drop at the next edge and the FSM SHALL enter TURN.
- timeout SHALL pulse high for exactly that first TURN cycle.
REQ-025 After a timeout, a still-requesting ex-owner SHALL compete normally. Because ptr already points past it, it is regranted only if no other requester is active.
REQ-026 With ARB_TIMEOUT_EN undefined, no counter SHALL be synthesised, ownership SHALL be unbounded, and timeout SHALL be tied to 0.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then req=0100 at edge 1: gnt=0100, slct=10, busy=1 from cycle 2; ptr=3.
- req=1111 held, each owner drops req for one cycle after 2 grant cycles: grant order 0,1,2,3,0 with slct 00,01,10,11,00, and exactly one TURN plus IDLE gap between each.
- Owner 1 holds, req[3] rises mid-ownership: gnt stays 0010 until req[1] falls, then gnt=1000 after the TURN cycle.
- rst pulsed while gnt=0001: next cycle gnt=0000, slct=00, busy=0; with req=0011 the next grant goes to index 0.
- ARB_TIMEOUT_EN defined, MAX_HOLD=8, req=0011 held high: gnt=0001 for exactly 8 cycles, timeout pulse for 1 cycle, then gnt=0010 for 8 cycles, alternating.
- ARB_TIMEOUT_EN undefined, same stimulus: gnt=0001 held for 100 cycles, timeout constant 0.
